conv2d_ctrl_param: RTL

CONV2D_CTRL_PARAM -- requirements
Module: conv2d_ctrl_param

---
 rtl/conv2d_ctrl_param.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv2d_ctrl_param.sv
// Conv2d layer controller: kernel fetch per channel, window/stream sequencing,
// zero padding, partial-sum buffer control and output beat generation.
// Ports:
//   clk, aresetn           clock, synchronous active-low reset
//   load_kernel            host fills kernel BRAM; falling edge starts a job
//   cfg_img/cfg_ch/cfg_pad image size N, channel count C, same-padding enable
//   s_axis_*               input pixel stream (tvalid/tlast in, tready out)
//   m_axis_*               output beat strobes (tready in, tvalid/tlast out)
//   kbram_en/kbram_addr    kernel BRAM read, wr_kernel loads kernel register
//   win_rst/shift/zero     sliding window control
//   acc_first/add_bias     accumulate control, obuf_we/obuf_addr buffer write
//   busy, done, err        job status (done pulses, err is sticky)
module conv2d_ctrl_param #(
   parameter int IMG_W = 8,
   parameter int CH_W  = 9,
   parameter int OA_W  = 14
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             load_kernel,
   input  logic [IMG_W-1:0] cfg_img,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic             cfg_pad,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   input  logic             m_axis_tready,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   output logic             kbram_en,
   output logic [CH_W-1:0]  kbram_addr,
   output logic             wr_kernel,
   output logic             win_rst,
   output logic             win_shift,
   output logic             win_zero,
   output logic             acc_first,
   output logic             add_bias,
   output logic             obuf_we,
   output logic [OA_W-1:0]  obuf_addr,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOADK, S_KRD, S_KWR, S_STREAM,
      S_PADCOL, S_PADROW, S_NEXTCH, S_FIN
   } state_t;

   localparam logic [IMG_W-1:0] I_ONE   = IMG_W'(1);
   localparam logic [IMG_W-1:0] I_THREE = IMG_W'(3);
   localparam logic [IMG_W:0]   Q_ONE   = (IMG_W+1)'(1);
   localparam logic [IMG_W:0]   Q_TWO   = (IMG_W+1)'(2);
   localparam logic [CH_W-1:0]  C_ONE   = CH_W'(1);
   localparam logic [OA_W-1:0]  O_ONE   = OA_W'(1);

   state_t           state_q, state_d;
   logic [IMG_W-1:0] n_q, n_d;
   logic [CH_W-1:0]  c_q, c_d;
   logic             pad_q, pad_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [IMG_W-1:0] row_q, row_d;
   logic [IMG_W-1:0] col_q, col_d;
   logic [OA_W-1:0]  oa_q, oa_d;
   logic             err_q, err_d;

   logic [IMG_W:0]   n_x, q, p;
   logic             in_stream, in_pad, last_ch;
   logic             col_last, row_last, col_end;
   logic             cfg_bad, out_pos, fin_pos;
   logic             s_rdy, xfer, m_vld, pad_adv;
   logic             shift, emit, exp_tlast;

   assign n_x       = {1'b0, n_q};
   assign in_stream = (state_q == S_STREAM);
   assign in_pad    = (state_q == S_PADCOL) ||
                      (state_q == S_PADROW);
   assign last_ch   = (ch_q == c_q - C_ONE);
   assign col_last  = (col_q == n_q - I_ONE);
   assign row_last  = (row_q == n_q - I_ONE);
   assign col_end   = (col_q == n_q);
   assign exp_tlast = row_last && col_last;

   assign cfg_bad = (cfg_ch == '0) ||
                    (cfg_img == '0) ||
                    (!cfg_pad && (cfg_img < I_THREE));

   // Position in the (optionally padded) frame; the padded frame has a
   // leading zero row/column, so coordinates are offset by one.
   always_comb begin
      q = {1'b0, row_q};
      p = {1'b0, col_q};
      if (pad_q) begin
         q = q + Q_ONE;
         p = p + Q_ONE;
         if (state_q == S_PADROW) q = n_x + Q_ONE;
      end
   end

   assign out_pos = (q >= Q_TWO) && (p >= Q_TWO);
   assign fin_pos = pad_q ?
      ((q == n_x + Q_ONE) && (p == n_x + Q_ONE)) :
      ((q == n_x - Q_ONE) && (p == n_x - Q_ONE));

   // Only the last channel produces results, so only it is throttled
   // by the downstream consumer.
   assign s_rdy   = in_stream && (last_ch ? m_axis_tready : 1'b1);
   assign xfer    = s_rdy && s_axis_tvalid;
   assign m_vld   = last_ch && out_pos &&
                    (in_stream ? s_axis_tvalid : in_pad);
   assign pad_adv = in_pad && !(m_vld && !m_axis_tready);
   assign shift   = xfer || pad_adv;
   assign emit    = shift && out_pos;

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         c_q     <= '0;
         pad_q   <= 1'b0;
         ch_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         oa_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         c_q     <= c_d;
         pad_q   <= pad_d;
         ch_q    <= ch_d;
         row_q   <= row_d;
         col_q   <= col_d;
         oa_q    <= oa_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      c_d     = c_q;
      pad_d   = pad_q;
      ch_d    = ch_q;
      row_d   = row_q;
      col_d   = col_q;
      oa_d    = oa_q;
      err_d   = err_q;
      if (emit) oa_d = oa_q + O_ONE;
      unique case (state_q)
         S_IDLE: begin
            if (load_kernel) state_d = S_LOADK;
         end
         S_LOADK: begin
            if (!load_kernel) begin
               n_d   = cfg_img;
               c_d   = cfg_ch;
               pad_d = cfg_pad;
               ch_d  = '0;
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_KRD;
               end
            end
         end
         S_KRD: state_d = S_KWR;
         S_KWR: begin
            row_d   = '0;
            col_d   = '0;
            oa_d    = '0;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (xfer) begin
               if (s_axis_tlast != exp_tlast) err_d = 1'b1;
               col_d = col_q + I_ONE;
               if (col_last) begin
                  if (pad_q) begin
                     state_d = S_PADCOL;
                  end else begin
                     col_d = '0;
                     row_d = row_q + I_ONE;
                     if (row_last) state_d = S_NEXTCH;
                  end
               end
            end
         end
         S_PADCOL: begin
            if (pad_adv) begin
               col_d   = '0;
               row_d   = row_q + I_ONE;
               state_d = row_last ? S_PADROW : S_STREAM;
            end
         end
         S_PADROW: begin
            if (pad_adv) begin
               col_d = col_q + I_ONE;
               if (col_end) state_d = S_NEXTCH;
            end
         end
         S_NEXTCH: begin
            ch_d    = ch_q + C_ONE;
            state_d = last_ch ? S_FIN : S_KRD;
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      s_axis_tready = s_rdy;
      m_axis_tvalid = m_vld;
      m_axis_tlast  = m_vld && fin_pos;
      kbram_en      = (state_q == S_KRD);
      kbram_addr    = (state_q == S_KRD) ? ch_q : '0;
      wr_kernel     = (state_q == S_KWR);
      win_rst       = (state_q == S_KWR);
      win_shift     = shift;
      win_zero      = pad_adv;
      acc_first     = emit && (ch_q == '0);
      add_bias      = emit && last_ch;
      obuf_we       = emit;
      obuf_addr     = oa_q;
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_FIN);
      err           = err_q;
   end

endmodule
